// File: rtl/wishbone_word_packer.sv
// Packs WORDS rising-edge writes into one wide operand, then returns the core's wide result one word at a time.
// Optional sticky overflow flag for dropped writes: define WB_PACKER_OVF_EN.
module wishbone_word_packer #(
    parameter int WORDS = 4,
    parameter int CNT_W = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic [WORDS*32-1:0]  op_data,
    output logic                 op_valid,
    input  logic                 op_ready,
    input  logic [WORDS*32-1:0]  res_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_pop,
`ifdef WB_PACKER_OVF_EN
    output logic                 ovf_o,
    input  logic                 ovf_clr_i,
`endif
    output logic                 busy
);

    // state   | meaning
    // S_FILL  | collecting write words into obuf
    // S_ISSUE | operand offered to core
    // S_WAIT  | waiting for core result
    // S_DRAIN | returning rbuf words on readback path
    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [WORDS*32-1:0]   obuf_q, obuf_d;
    logic [WORDS*32-1:0]   rbuf_q, rbuf_d;
    logic                  in_valid_q, in_valid_d;
    logic                  accept;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        obuf_d     = obuf_q;
        rbuf_d     = rbuf_q;
        in_valid_d = in_valid;
        accept     = in_valid & ~in_valid_q;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (wr_cnt_q == CNT_W'(k)) obuf_d[32*k +: 32] = in_data;
                    end
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_ISSUE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (op_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid) begin
                    rbuf_d   = res_data;
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_pop) begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = S_FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        op_data   = obuf_q;
        op_valid  = (state_q == S_ISSUE);
        res_ready = (state_q == S_WAIT);
        out_valid = (state_q == S_DRAIN);
        busy      = (state_q != S_FILL);
        out_data  = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (rd_cnt_q == CNT_W'(k)) out_data = rbuf_q[32*k +: 32];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_FILL;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            obuf_q     <= '0;
            rbuf_q     <= '0;
            in_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            obuf_q     <= obuf_d;
            rbuf_q     <= rbuf_d;
            in_valid_q <= in_valid_d;
        end
    end

`ifdef WB_PACKER_OVF_EN
    logic ovf_q, ovf_d;

    // A set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (accept && (state_q != S_FILL)) ovf_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_wishbone_word_packer.sv
// Directed self-checking bench for wishbone_word_packer (WORDS=4).
module tb_wishbone_word_packer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [127:0] op_data;
    logic         op_valid;
    logic         op_ready;
    logic [127:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_pop;
    logic         busy;
`ifdef WB_PACKER_OVF_EN
    logic         ovf_o;
    logic         ovf_clr_i;
`endif

    int checks   = 0;
    int failures = 0;

    wishbone_word_packer #(.WORDS(4), .CNT_W(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .op_data   (op_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_pop   (out_pop),
`ifdef WB_PACKER_OVF_EN
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [127:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        op_ready  = 1'b0;
        res_data  = '0;
        res_valid = 1'b0;
        out_pop   = 1'b0;
`ifdef WB_PACKER_OVF_EN
        ovf_clr_i = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        chk("rst_op_valid", op_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_data", op_data, 0);
        chk("rst_out_data", out_data, 0);
`ifdef WB_PACKER_OVF_EN
        chk("rst_ovf", ovf_o, 0);
`endif

        // Fill with four words.
        write_word(32'h11);
        write_word(32'h22);
        write_word(32'h33);
        chk("fill3_busy", busy, 0);
        write_word(32'h44);
        chk("fill_op_valid", op_valid, 1);
        chk("fill_op_data", op_data, 128'h00000044_00000033_00000022_00000011);
        chk("fill_busy", busy, 1);

        // Back-pressure then handshake.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_op_valid", op_valid, 1);
            chk("stall_op_data", op_data, 128'h00000044_00000033_00000022_00000011);
            chk("stall_res_ready", res_ready, 0);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("hs_op_valid", op_valid, 0);
        chk("hs_res_ready", res_ready, 1);

        // Result capture and readback.
        res_data  = {32'hD, 32'hC, 32'hB, 32'hA};
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        res_data  = '0;
        chk("res_ready_drop", res_ready, 0);
        chk("first_out_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("drain_word", out_data, 128'(32'hA + k));
            out_pop = 1'b1;
            tick();
            out_pop = 1'b0;
        end
        chk("drain_done_busy", busy, 0);
        chk("drain_done_out_valid", out_valid, 0);

        // Held level counts once.
        in_valid = 1'b1;
        in_data  = 32'h55;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        tick();
        chk("held_wr_cnt", dut.wr_cnt_q, 1);
        chk("held_busy", busy, 0);
        write_word(32'h66);
        write_word(32'h77);
        write_word(32'h88);
        chk("held_op_valid", op_valid, 1);
        chk("held_op_data", op_data, 128'h00000088_00000077_00000066_00000055);

        // Reset from ISSUE, then a partial operand discarded by reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_issue_op_valid", op_valid, 0);
        write_word(32'hA1);
        write_word(32'hA2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_part_wr_cnt", dut.wr_cnt_q, 0);
        chk("rst_part_op_data", op_data, 0);
        write_word(32'hB1);
        write_word(32'hB2);
        write_word(32'hB3);
        write_word(32'hB4);
        chk("new_op_data", op_data, 128'h000000B4_000000B3_000000B2_000000B1);
        chk("new_op_valid", op_valid, 1);

        // Dropped write during WAIT.
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        held = 128'h000000B4_000000B3_000000B2_000000B1;
        in_valid = 1'b1;
        in_data  = 32'hEE;
        tick();
`ifdef WB_PACKER_OVF_EN
        chk("ovf_set", ovf_o, 1);
`endif
        in_valid = 1'b0;
        tick();
        chk("drop_wr_cnt", dut.wr_cnt_q, 0);
        chk("drop_op_data", op_data, held);
        chk("drop_res_ready", res_ready, 1);

        res_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        res_data  = '0;
        chk("drop_out_word0", out_data, 1);

`ifdef WB_PACKER_OVF_EN
        ovf_clr_i = 1'b1;
        in_valid  = 1'b1;
        tick();
        chk("ovf_set_wins", ovf_o, 1);
        ovf_clr_i = 1'b0;
        in_valid  = 1'b0;
        tick();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clear", ovf_o, 0);
`endif

        for (int k = 0; k < 3; k++) begin
            chk("drop_drain_word", out_data, 128'(k + 1));
            out_pop = 1'b1;
            tick();
            out_pop = 1'b0;
        end
        chk("last_word", out_data, 4);
        // Accept edge coinciding with the final pop is dropped.
        out_pop  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h99;
        tick();
        out_pop  = 1'b0;
        chk("last_pop_busy", busy, 0);
        chk("last_pop_out_valid", out_valid, 0);
        chk("last_pop_wr_cnt", dut.wr_cnt_q, 0);
        in_valid = 1'b0;
        tick();
        chk("after_pop_wr_cnt", dut.wr_cnt_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
